// File: rtl/instruction_fetch.sv
// Instruction fetch unit: sequential PC generation feeding a small {pc, instr} buffer.
// Optional macro FETCH_MISALIGN_CHECK_EN enables the sticky misaligned-redirect fault.
module instruction_fetch #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc,
   output logic        fault
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   logic [63:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic          fault_q, fault_d;
   logic [63:0]   pc_mem_q [FIFO_DEPTH];
   logic [63:0]   pc_mem_d [FIFO_DEPTH];
   logic [31:0]   instr_mem_q [FIFO_DEPTH];
   logic [31:0]   instr_mem_d [FIFO_DEPTH];
   logic          pop;
   logic          push;

   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      fault_d     = fault_q;
      pc_mem_d    = pc_mem_q;
      instr_mem_d = instr_mem_q;
      pop         = (count_q != '0) && out_ready;
      push        = 1'b0;

      if (redirect_valid) begin
         // A handshake coinciding with a redirect is consumed and dropped with the flush.
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
         fetch_pc_d = redirect_pc;
         if (redirect_pc[1:0] != 2'b00) fault_d = 1'b1;
`else
         fetch_pc_d = redirect_pc & ~64'h3;
         fault_d    = 1'b0;
`endif
      end else begin
         push = !fault_q && ((count_q != FULL) || pop);
         if (push) begin
            pc_mem_d[wr_ptr_q]    = fetch_pc_q;
            instr_mem_d[wr_ptr_q] = imem_instr;
            wr_ptr_d              = wr_ptr_q + PW'(1);
            fetch_pc_d            = fetch_pc_q + 64'd4;
         end
         if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
         if (push && !pop) count_d = count_q + CW'(1);
         else if (!push && pop) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         fault_q    <= 1'b0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         fault_q     <= fault_d;
         pc_mem_q    <= pc_mem_d;
         instr_mem_q <= instr_mem_d;
      end
   end

   assign imem_addr = fetch_pc_q;
   assign out_valid = (count_q != '0);
   assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
   assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : '0;
   assign fault     = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: vector table plus hand sequences, with a queue scoreboard
// checking every consumed entry against an independent fetch-order model.
module tb_instruction_fetch;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        fault;

   int checks = 0;
   int errors = 0;

   logic [63:0] sb_q[$];
   logic [63:0] m_pc;
   logic        m_fault;

   typedef struct {
      logic        rdy;
      logic        rv;
      logic [63:0] rpc;
      logic        ev;
      logic [63:0] epc;
      logic [63:0] eaddr;
   } vec_t;

   vec_t vec[21];

   instruction_fetch #(.RESET_PC(64'h0), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .fault(fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a == 64'h0) return 32'h00500093;
      return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h13;
   endfunction

   always_comb imem_instr = mem_word(imem_addr);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drive one cycle from a negedge, update the model, check after the rising edge.
   task automatic step(input logic rdy, input logic rv, input logic [63:0] rpc);
      logic pop;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      pop = (sb_q.size() != 0) && rdy;
      if (pop) begin
         chk("sb_pc", out_pc, sb_q[0]);
         chk("sb_instr", {32'h0, out_instr}, {32'h0, mem_word(sb_q[0])});
      end
      if (rv) begin
         sb_q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
         if (rpc[1:0] != 2'b00) m_fault = 1'b1;
         m_pc = rpc;
`else
         m_pc = rpc & ~64'h3;
`endif
      end else begin
         if (pop) void'(sb_q.pop_front());
         if (!m_fault && sb_q.size() < DEPTH) begin
            sb_q.push_back(m_pc);
            m_pc = m_pc + 64'd4;
         end
      end
      @(posedge clk);
      #1;
      chk("m_valid", {63'h0, out_valid}, {63'h0, sb_q.size() != 0});
      chk("m_pc", out_pc, (sb_q.size() != 0) ? sb_q[0] : 64'h0);
      chk("m_addr", imem_addr, m_pc);
      chk("m_fault", {63'h0, fault}, {63'h0, m_fault});
      @(negedge clk);
   endtask

   // Asynchronous reset: outputs must clear before any clock edge.
   task automatic do_reset();
      #2 reset = 1'b0;
      sb_q.delete();
      m_pc    = 64'h0;
      m_fault = 1'b0;
      #1;
      chk("rst_valid", {63'h0, out_valid}, 64'h0);
      chk("rst_pc", out_pc, 64'h0);
      chk("rst_instr", {32'h0, out_instr}, 64'h0);
      chk("rst_addr", imem_addr, 64'h0);
      chk("rst_fault", {63'h0, fault}, 64'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset          = 1'b1;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      m_pc           = 64'h0;
      m_fault        = 1'b0;

      vec[0]  = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h0,   64'h4};
      vec[1]  = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h0,   64'h8};
      vec[2]  = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h0,   64'hC};
      vec[3]  = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h0,   64'h10};
      for (int i = 4; i < 10; i++) vec[i] = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h0, 64'h10};
      vec[10] = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h4,   64'h14};
      vec[11] = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h8,   64'h18};
      vec[12] = '{1'b1, 1'b0, 64'h0,   1'b1, 64'hC,   64'h1C};
      vec[13] = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h10,  64'h20};
      vec[14] = '{1'b0, 1'b1, 64'h100, 1'b0, 64'h0,   64'h100};
      vec[15] = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h100, 64'h104};
      vec[16] = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h100, 64'h108};
      vec[17] = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h100, 64'h10C};
      vec[18] = '{1'b1, 1'b1, 64'h40,  1'b0, 64'h0,   64'h40};
      vec[19] = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h40,  64'h44};
      vec[20] = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h44,  64'h48};

      do_reset();

      // Reset release with consumer ready.
      step(1'b1, 1'b0, 64'h0);
      chk("first_valid", {63'h0, out_valid}, 64'h1);
      chk("first_pc", out_pc, 64'h0);
      chk("first_instr", {32'h0, out_instr}, 64'h00500093);
      step(1'b1, 1'b0, 64'h0);
      chk("second_pc", out_pc, 64'h4);

      do_reset();
      for (int i = 0; i < 21; i++) begin
         step(vec[i].rdy, vec[i].rv, vec[i].rpc);
         chk($sformatf("vec%0d_valid", i), {63'h0, out_valid}, {63'h0, vec[i].ev});
         chk($sformatf("vec%0d_pc", i), out_pc, vec[i].epc);
         chk($sformatf("vec%0d_addr", i), imem_addr, vec[i].eaddr);
      end

      // Misaligned redirect.
      step(1'b1, 1'b1, 64'h42);
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("mis_fault", {63'h0, fault}, 64'h1);
      chk("mis_addr", imem_addr, 64'h42);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 64'h0);
         chk("mis_hold_valid", {63'h0, out_valid}, 64'h0);
         chk("mis_hold_fault", {63'h0, fault}, 64'h1);
      end
`else
      chk("mis_addr", imem_addr, 64'h40);
      step(1'b1, 1'b0, 64'h0);
      chk("mis_pc", out_pc, 64'h40);
      chk("mis_fault", {63'h0, fault}, 64'h0);
`endif

      do_reset();
      step(1'b1, 1'b0, 64'h0);
      // Address wrap at the top of the 64-bit space.
      step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_valid0", {63'h0, out_valid}, 64'h0);
      step(1'b1, 1'b0, 64'h0);
      chk("wrap_pc_top", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_addr", imem_addr, 64'h0);
      step(1'b1, 1'b0, 64'h0);
      chk("wrap_pc_zero", out_pc, 64'h0);
      step(1'b0, 1'b0, 64'h0);
      step(1'b0, 1'b0, 64'h0);

      // Mid-operation reset with entries in flight.
      do_reset();
      step(1'b0, 1'b0, 64'h0);
      chk("post_rst_pc", out_pc, 64'h0);
      chk("post_rst_addr", imem_addr, 64'h4);

      for (int i = 0; i < 60; i++) begin
         logic [63:0] r;
         r = {32'($urandom), 32'($urandom)} & ~64'h3;
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), r);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
